// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_pkg
// Brief    : Shared types, note frequency table and half-period helper for
//            the note sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package note_pkg;

  // Note index as presented to the scope character lookup
  typedef enum logic [2:0] {
    NOTE_DO  = 3'd0,
    NOTE_RE  = 3'd1,
    NOTE_MI  = 3'd2,
    NOTE_FA  = 3'd3,
    NOTE_SO  = 3'd4,
    NOTE_LA  = 3'd5,
    NOTE_SI  = 3'd6,
    NOTE_DO2 = 3'd7
  } note_t;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } seq_state_t;

  // Note frequencies in Hz, indexed by note_t
  localparam int unsigned NOTE_HZ [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};

  // Half period in clock cycles (truncated); evaluated at elaboration time only
  function automatic int unsigned half_period(input int unsigned clk_hz, input note_t n);
    return clk_hz / (2 * NOTE_HZ[n]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer_if
// Brief    : Control and status bundle of the note sequencer. The controller
//            side (master) drives mode/selection/start/stop; the sequencer
//            (slave) drives audio and status.
// Revision : 1.0 - initial release
// ============================================================================
interface note_sequencer_if;
  logic       mode;
  logic [2:0] manual_sel;
  logic       start;
  logic       stop;
  logic       audio_out;
  logic [2:0] note_idx;
  logic       playing;
  logic       note_change;

  modport master (
    output mode, manual_sel, start, stop,
    input  audio_out, note_idx, playing, note_change
  );

  modport slave (
    input  mode, manual_sel, start, stop,
    output audio_out, note_idx, playing, note_change
  );
endinterface
`default_nettype wire

// File: rtl/note_sequencer_tone_divider.sv
`default_nettype none
// ============================================================================
// Module   : tone_divider
// Brief    : Square-wave generator. Counts 0..half_period-1 and toggles the
//            output at the terminal count. Clear, disable or reset force the
//            counter and output low, so a fresh note always starts low and
//            rises exactly half_period cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module tone_divider #(
  parameter int HW = 11
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic [HW-1:0] i_half_period,
  input  wire logic          i_clear,
  input  wire logic          i_enable,
  output logic               o_wave
);

  logic [HW-1:0] r_cnt;
  logic          r_wave;

  // Half-period counter and output toggle; silent whenever not enabled
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear || !i_enable) begin
      r_cnt  <= '0;
      r_wave <= 1'b0;
    end else if (r_cnt == (i_half_period - HW'(1))) begin
      r_cnt  <= '0;
      r_wave <= ~r_wave;
    end else begin
      r_cnt  <= r_cnt + HW'(1);
    end
  end

  assign o_wave = r_wave;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : note_sequencer
// Brief    : Note selection, tone generation and sequencing. Manual mode
//            follows manual_sel; auto mode steps DO..DO2 with a fixed dwell
//            and an optional silent gap between notes.
// Revision : 1.0 - initial release
// ============================================================================
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000
) (
  input  wire logic        CLOCK_50,
  input  wire logic        reset_n,
  note_sequencer_if.slave  bus
);

  // Lowest note has the longest half period and sets the divider width
  localparam int unsigned c_MAX_HALF = half_period(CLK_HZ, NOTE_DO);
  localparam int          c_HW       = $clog2(c_MAX_HALF) + 1;
  localparam int          c_DW       = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int          c_GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL_CYCLES - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [c_HW-1:0] c_HALF [8] = '{
    c_HW'(half_period(CLK_HZ, NOTE_DO)),
    c_HW'(half_period(CLK_HZ, NOTE_RE)),
    c_HW'(half_period(CLK_HZ, NOTE_MI)),
    c_HW'(half_period(CLK_HZ, NOTE_FA)),
    c_HW'(half_period(CLK_HZ, NOTE_SO)),
    c_HW'(half_period(CLK_HZ, NOTE_LA)),
    c_HW'(half_period(CLK_HZ, NOTE_SI)),
    c_HW'(half_period(CLK_HZ, NOTE_DO2))
  };

  seq_state_t      r_state;
  note_t           r_note_idx;
  logic            r_mode;
  logic            r_playing;
  logic            r_note_change;
  logic [c_DW-1:0] r_dwell;
  logic [c_GW-1:0] r_gap;

  seq_state_t      w_state_nxt;
  note_t           w_idx_nxt;
  logic            w_mode_nxt;
  logic [c_DW-1:0] w_dwell_nxt;
  logic [c_GW-1:0] w_gap_nxt;
  logic            w_entry;
  logic            w_tone_en;
  logic            w_audio;

  // Next-state decode; w_entry marks the edge at which a new note is presented
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_note_idx;
    w_mode_nxt  = r_mode;
    w_dwell_nxt = r_dwell;
    w_gap_nxt   = r_gap;
    w_entry     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = S_PLAY;
          w_mode_nxt  = bus.mode;
          w_idx_nxt   = bus.mode ? NOTE_DO : note_t'(bus.manual_sel);
          w_entry     = 1'b1;
          w_dwell_nxt = '0;
          w_gap_nxt   = '0;
        end
      end
      S_PLAY: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
          w_dwell_nxt = '0;
          w_gap_nxt   = '0;
        end else if (!r_mode) begin
          // A change right after a pulse is deferred one cycle so pulses never abut
          if ((note_t'(bus.manual_sel) != r_note_idx) && !r_note_change) begin
            w_idx_nxt = note_t'(bus.manual_sel);
            w_entry   = 1'b1;
          end
        end else if (r_dwell == c_DWELL_LAST) begin
          w_dwell_nxt = '0;
          if (GAP_CYCLES == 0) begin
            w_idx_nxt = note_t'(r_note_idx + 3'd1);
            w_entry   = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
          end
        end else begin
          w_dwell_nxt = r_dwell + c_DW'(1);
        end
      end
      S_GAP: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else if (r_gap == c_GAP_LAST) begin
          w_state_nxt = S_PLAY;
          w_idx_nxt   = note_t'(r_note_idx + 3'd1);
          w_entry     = 1'b1;
          w_gap_nxt   = '0;
          w_dwell_nxt = '0;
        end else begin
          w_gap_nxt = r_gap + c_GW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered status outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_note_idx    <= NOTE_DO;
      r_mode        <= 1'b0;
      r_playing     <= 1'b0;
      r_note_change <= 1'b0;
      r_dwell       <= '0;
      r_gap         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_note_idx    <= w_idx_nxt;
      r_mode        <= w_mode_nxt;
      r_playing     <= (w_state_nxt != S_IDLE);
      r_note_change <= w_entry;
      r_dwell       <= w_dwell_nxt;
      r_gap         <= w_gap_nxt;
    end
  end

  // Tone runs only while staying in PLAY; leaving PLAY silences it on the same edge
  assign w_tone_en = (r_state == S_PLAY) && (w_state_nxt == S_PLAY);

  tone_divider #(
    .HW (c_HW)
  ) u_tone (
    .clk           (CLOCK_50),
    .reset_n       (reset_n),
    .i_half_period (c_HALF[r_note_idx]),
    .i_clear       (w_entry),
    .i_enable      (w_tone_en),
    .o_wave        (w_audio)
  );

  assign bus.audio_out   = w_audio;
  assign bus.note_idx    = r_note_idx;
  assign bus.playing     = r_playing;
  assign bus.note_change = r_note_change;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_sequencer
// Brief    : Scoreboard bench for note_sequencer. Stimulus queues the expected
//            note index and half period for every note entry; the monitor
//            checks each note_change pulse against the queue and times the
//            first rise and fall of audio_out after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;

  typedef struct {
    int idx;
    int half;
  } exp_t;

  // Half periods at 1 MHz: 1e6 / (2*f), truncated
  int HALF [8] = '{956, 851, 758, 716, 638, 568, 506, 478};

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  note_sequencer_if bus ();

  note_sequencer #(
    .CLK_HZ       (1_000_000),
    .DWELL_CYCLES (2000),
    .GAP_CYCLES   (100)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   pulses_seen = 0;

  // Monitor-only tracking state
  logic prev_audio = 1'b0;
  bit   trk_active = 1'b0;
  int   trk_cnt    = 0;
  int   trk_half   = 0;
  int   trk_edges  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_note(input int idx);
    exp_t e;
    e.idx  = idx;
    e.half = HALF[idx];
    q.push_back(e);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int i = 0;
    while (pulses_seen < target && i < budget) begin
      tick(1);
      i++;
    end
    chk("pulse_count", pulses_seen, target);
  endtask

  // Scoreboard monitor: pop on every note_change, then time audio edges
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      trk_active = 1'b0;
      prev_audio = 1'b0;
    end else begin
      if (trk_active) trk_cnt++;
      if (bus.note_change) begin
        pulses_seen++;
        if (q.size() == 0) begin
          chk("unexpected_note_change", int'(bus.note_idx), -1);
        end else begin
          e = q.pop_front();
          chk("note_idx_on_change", int'(bus.note_idx), e.idx);
          chk("playing_on_change", int'(bus.playing), 1);
          chk("audio_low_on_change", int'(bus.audio_out), 0);
          trk_active = 1'b1;
          trk_cnt    = 0;
          trk_half   = e.half;
          trk_edges  = 0;
        end
      end else if (trk_active && (bus.audio_out != prev_audio)) begin
        chk(trk_edges == 0 ? "first_rise_delay" : "fall_delay", trk_cnt, trk_half);
        trk_cnt = 0;
        trk_edges++;
        if (trk_edges == 2) trk_active = 1'b0;
      end
      if (!bus.playing) trk_active = 1'b0;
      prev_audio = bus.audio_out;
    end
  end

  initial begin
    bus.mode       = 1'b0;
    bus.manual_sel = 3'd0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;

    // Reset held for three cycles
    tick(3);
    chk("rst_audio", int'(bus.audio_out), 0);
    chk("rst_note_idx", int'(bus.note_idx), 0);
    chk("rst_playing", int'(bus.playing), 0);
    chk("rst_note_change", int'(bus.note_change), 0);
    reset_n = 1'b1;
    tick(2);

    // Manual LA
    bus.mode = 1'b0;
    bus.manual_sel = 3'd5;
    push_note(5);
    pulse_start();
    tick(1300);
    chk("manual_note_idx", int'(bus.note_idx), 5);
    chk("manual_playing", int'(bus.playing), 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("stop_playing", int'(bus.playing), 0);
    chk("stop_audio", int'(bus.audio_out), 0);
    chk("stop_idx_retained", int'(bus.note_idx), 5);
    tick(5);

    // Manual change MI -> FA, with a mode toggle that must be ignored
    bus.manual_sel = 3'd2;
    push_note(2);
    pulse_start();
    tick(100);
    push_note(3);
    bus.manual_sel = 3'd3;
    tick(1);
    chk("manual_change_idx", int'(bus.note_idx), 3);
    bus.mode = 1'b1;
    tick(1500);
    chk("mode_ignored_idx", int'(bus.note_idx), 3);
    chk("mode_ignored_playing", int'(bus.playing), 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    tick(5);

    // Auto sequence through the wrap: DO..DO2 then DO again
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) push_note(i);
    push_note(0);
    pulse_start();
    tick(2050);
    chk("gap_audio", int'(bus.audio_out), 0);
    chk("gap_playing", int'(bus.playing), 1);
    chk("gap_note_idx", int'(bus.note_idx), 0);
    wait_pulses(12, 20000);
    chk("queue_drained_after_wrap", q.size(), 0);

    // Stop during a gap, then start&stop together in IDLE
    push_note(1);
    wait_pulses(13, 3000);
    tick(2030);
    chk("gap2_audio", int'(bus.audio_out), 0);
    chk("gap2_playing", int'(bus.playing), 1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("gap_stop_playing", int'(bus.playing), 0);
    chk("gap_stop_audio", int'(bus.audio_out), 0);
    chk("gap_stop_idx", int'(bus.note_idx), 1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick(3);
    chk("start_stop_idle", int'(bus.playing), 0);

    // Reset pulse mid auto PLAY, then restart at note 0
    push_note(0);
    pulse_start();
    tick(500);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("midrst_audio", int'(bus.audio_out), 0);
    chk("midrst_note_idx", int'(bus.note_idx), 0);
    chk("midrst_playing", int'(bus.playing), 0);
    chk("midrst_note_change", int'(bus.note_change), 0);
    tick(3000);
    chk("midrst_stays_idle", int'(bus.playing), 0);
    bus.manual_sel = 3'd6;
    push_note(0);
    pulse_start();
    tick(1200);
    chk("restart_idx", int'(bus.note_idx), 0);
    chk("restart_playing", int'(bus.playing), 1);
    chk("total_pulses", pulses_seen, 15);
    chk("queue_empty_end", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
